// File: rtl/amiv_fb_arbiter_if.sv
// Bus bundle between the framebuffer arbiter and its clients/controller.
// The slave modport is the arbiter's view; master is the surrounding system.
interface amiv_fb_arbiter_if;
  logic        in_wr_valid;
  logic [18:0] in_wr_addr;
  logic [15:0] in_wr_data;
  logic        out_wr_ready;
  logic        in_rd_req;
  logic [18:0] in_rd_addr;
  logic        out_rd_ready;
  logic        out_rd_valid;
  logic [15:0] out_rd_data;
  logic        out_sram_start_n;
  logic        out_sram_rw;
  logic        out_sram_fast_write;
  logic [18:0] out_sram_addr;
  logic [15:0] out_sram_data;
  logic        in_sram_busy_n;
  logic [15:0] in_sram_data;

  modport slave (
    input  in_wr_valid, in_wr_addr, in_wr_data, in_rd_req, in_rd_addr,
           in_sram_busy_n, in_sram_data,
    output out_wr_ready, out_rd_ready, out_rd_valid, out_rd_data,
           out_sram_start_n, out_sram_rw, out_sram_fast_write,
           out_sram_addr, out_sram_data
  );

  modport master (
    output in_wr_valid, in_wr_addr, in_wr_data, in_rd_req, in_rd_addr,
           in_sram_busy_n, in_sram_data,
    input  out_wr_ready, out_rd_ready, out_rd_valid, out_rd_data,
           out_sram_start_n, out_sram_rw, out_sram_fast_write,
           out_sram_addr, out_sram_data
  );
endinterface

// File: rtl/amiv_fb_arbiter.sv
// Framebuffer SRAM arbiter: priority scanout reads, FIFO-buffered capture
// writes, and a starvation limit that forces a write after STARVE_MAX reads.
module amiv_fb_arbiter #(
  parameter int FIFO_AW    = 2,
  parameter int STARVE_MAX = 8
) (
  input logic              in_clk,
  input logic              in_reset,
  amiv_fb_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [34:0]        fifo_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               rd_pend_q, rd_pend_d;
  logic [18:0]        rd_addr_q;
  logic               start_n_q, start_n_d;
  logic               rw_q, rw_d;
  logic [18:0]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               rd_valid_q, rd_valid_d;
  logic [15:0]        rd_data_q, rd_data_d;

  logic fifo_empty_s, fifo_full_s, push_s, rd_accept_s, rd_want_s, forced_s;
  logic grant_rd_s, grant_wr_s, rd_done_s;

  assign fifo_empty_s = (count_q == (FIFO_AW + 1)'(0));
  assign fifo_full_s  = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign push_s       = bus.in_wr_valid & ~fifo_full_s;
  assign rd_accept_s  = bus.in_rd_req & ~rd_pend_q;
  // A read accepted in the same IDLE cycle competes too, so back-to-back
  // scanout reads are not interleaved with writes after every completion.
  assign rd_want_s    = rd_pend_q | rd_accept_s;
  assign forced_s     = (starve_q == SW'(STARVE_MAX)) & ~fifo_empty_s;

  assign bus.out_wr_ready        = ~fifo_full_s;
  assign bus.out_rd_ready        = ~rd_pend_q;
  assign bus.out_rd_valid        = rd_valid_q;
  assign bus.out_rd_data         = rd_data_q;
  assign bus.out_sram_start_n    = start_n_q;
  assign bus.out_sram_rw         = rw_q;
  assign bus.out_sram_fast_write = 1'b0;
  assign bus.out_sram_addr       = addr_q;
  assign bus.out_sram_data       = data_q;

  // Arbitration, request sequencing and read completion
  always_comb begin
    state_d    = state_q;
    start_n_d  = start_n_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    rd_done_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        start_n_d = 1'b1;
        if (bus.in_sram_busy_n && rd_want_s && !forced_s) begin
          grant_rd_s = 1'b1;
          rw_d       = 1'b1;
          addr_d     = rd_pend_q ? rd_addr_q : bus.in_rd_addr;
          start_n_d  = 1'b0;
          state_d    = S_ISSUE;
        end else if (bus.in_sram_busy_n && !fifo_empty_s) begin
          grant_wr_s       = 1'b1;
          rw_d             = 1'b0;
          {addr_d, data_d} = fifo_q[rd_ptr_q];
          start_n_d        = 1'b0;
          state_d          = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!bus.in_sram_busy_n) begin
          start_n_d = 1'b1;
          state_d   = S_WAIT;
        end else begin
          start_n_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.in_sram_busy_n) begin
          state_d = S_IDLE;
          if (rw_q) begin
            rd_data_d  = bus.in_sram_data;
            rd_valid_d = 1'b1;
            rd_done_s  = 1'b1;
          end else begin
            rd_done_s = 1'b0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        start_n_d = 1'b1;
      end
    endcase
  end

  // Pending-read flag, FIFO occupancy and starvation counter next state
  always_comb begin
    rd_pend_d = rd_pend_q;
    count_d   = count_q;
    starve_d  = starve_q;
    if (rd_done_s) begin
      rd_pend_d = 1'b0;
    end else if (rd_accept_s) begin
      rd_pend_d = 1'b1;
    end else begin
      rd_pend_d = rd_pend_q;
    end
    case ({push_s, grant_wr_s})
      2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (fifo_empty_s || grant_wr_s) begin
      starve_d = SW'(0);
    end else if (grant_rd_s && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State, request and FIFO registers
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= 19'd0;
      start_n_q  <= 1'b1;
      rw_q       <= 1'b1;
      addr_q     <= 19'd0;
      data_q     <= 16'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 16'd0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 35'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      rd_pend_q  <= rd_pend_d;
      start_n_q  <= start_n_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      if (rd_accept_s) rd_addr_q <= bus.in_rd_addr;
      if (push_s) begin
        fifo_q[wr_ptr_q] <= {bus.in_wr_addr, bus.in_wr_data};
        wr_ptr_q         <= wr_ptr_q + FIFO_AW'(1);
      end
      if (grant_wr_s) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
    end
  end
endmodule

// File: tb/tb_amiv_fb_arbiter.sv
// Directed bench for amiv_fb_arbiter with a simple SRAM controller model.
module tb_amiv_fb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amiv_fb_arbiter_if bus ();

  amiv_fb_arbiter #(.FIFO_AW(2), .STARVE_MAX(8)) dut (
    .in_clk   (clk),
    .in_reset (rst),
    .bus      (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int rdv_cnt  = 0;

  // controller model state
  logic        hold = 1'b0;
  logic        m_busy_n = 1'b1;
  logic        m_st = 1'b0;
  logic        m_rw = 1'b0;
  logic [18:0] m_addr = 19'd0;
  logic [15:0] m_data = 16'd0;
  int          m_cnt = 0;
  int          m_lat = 2;
  logic [35:0] log_q[$];

  assign bus.in_sram_busy_n = m_busy_n & ~hold;
  assign bus.in_sram_data   = m_data;

  function automatic logic [15:0] rdfn(input logic [18:0] a);
    return a[15:0] ^ 16'hEDCB;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SRAM controller model: logs each request, busy for m_lat cycles
  always @(negedge clk) begin
    if (rst) begin
      m_st     <= 1'b0;
      m_busy_n <= 1'b1;
    end else if (!m_st) begin
      if (!hold && bus.out_sram_start_n == 1'b0) begin
        log_q.push_back({bus.out_sram_rw, bus.out_sram_addr, bus.out_sram_data});
        m_rw     <= bus.out_sram_rw;
        m_addr   <= bus.out_sram_addr;
        m_busy_n <= 1'b0;
        m_cnt    <= m_lat;
        m_st     <= 1'b1;
      end
    end else begin
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else begin
        m_busy_n <= 1'b1;
        if (m_rw) m_data <= rdfn(m_addr);
        m_st <= 1'b0;
      end
    end
  end

  // read-valid pulse counter
  always @(negedge clk) begin
    if (bus.out_rd_valid) rdv_cnt <= rdv_cnt + 1;
  end

  task automatic push(input logic [18:0] a, input logic [15:0] d);
    int t = 0;
    bus.in_wr_valid = 1'b1;
    bus.in_wr_addr  = a;
    bus.in_wr_data  = d;
    while (!bus.out_wr_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check_eq("push_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus.in_wr_valid = 1'b0;
  endtask

  task automatic read(input logic [18:0] a);
    bus.in_rd_req  = 1'b1;
    bus.in_rd_addr = a;
    @(negedge clk);
    bus.in_rd_req  = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    int t = 0;
    while (log_q.size() < n && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, 64'(log_q.size() >= n), 64'd1);
  endtask

  initial begin
    int base, v0, t;
    logic early;
    logic [35:0] e;
    bus.in_wr_valid = 1'b0;
    bus.in_wr_addr  = 19'd0;
    bus.in_wr_data  = 16'd0;
    bus.in_rd_req   = 1'b0;
    bus.in_rd_addr  = 19'd0;

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_start_n", 64'(bus.out_sram_start_n), 64'd1);
    check_eq("rst_rw", 64'(bus.out_sram_rw), 64'd1);
    check_eq("rst_addr", 64'(bus.out_sram_addr), 64'd0);
    check_eq("rst_data", 64'(bus.out_sram_data), 64'd0);
    check_eq("rst_rd_valid", 64'(bus.out_rd_valid), 64'd0);
    check_eq("rst_rd_data", 64'(bus.out_rd_data), 64'd0);
    check_eq("rst_wr_ready", 64'(bus.out_wr_ready), 64'd1);
    check_eq("rst_rd_ready", 64'(bus.out_rd_ready), 64'd1);
    check_eq("rst_fast_write", 64'(bus.out_sram_fast_write), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single write
    check_eq("t1_wr_ready", 64'(bus.out_wr_ready), 64'd1);
    push(19'h00010, 16'hA5A5);
    wait_log(1, "t1_issued");
    check_eq("t1_req", 64'(log_q[0]), 64'({1'b0, 19'h00010, 16'hA5A5}));
    repeat (20) @(negedge clk);
    check_eq("t1_no_extra", 64'(log_q.size()), 64'd1);
    check_eq("t1_wr_ready_after", 64'(bus.out_wr_ready), 64'd1);

    // 2: single read
    base = log_q.size();
    read(19'h7FFFF);
    check_eq("t2_rd_ready_low", 64'(bus.out_rd_ready), 64'd0);
    early = 1'b0;
    t = 0;
    while (!bus.out_rd_valid && t < 100) begin
      if (bus.out_rd_ready) early = 1'b1;
      @(negedge clk);
      t++;
    end
    check_eq("t2_rd_valid_seen", 64'(bus.out_rd_valid), 64'd1);
    check_eq("t2_rd_ready_held", 64'(early), 64'd0);
    check_eq("t2_rd_data", 64'(bus.out_rd_data), 64'h1234);
    check_eq("t2_req_rw", 64'(log_q[base][35]), 64'd1);
    check_eq("t2_req_addr", 64'(log_q[base][34:16]), 64'h7FFFF);
    @(negedge clk);
    check_eq("t2_pulse_width", 64'(bus.out_rd_valid), 64'd0);
    repeat (5) @(negedge clk);
    check_eq("t2_rd_data_held", 64'(bus.out_rd_data), 64'h1234);

    // 3: fill FIFO while controller busy
    hold = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 4; i++) push(19'h00100 + 19'(i), 16'hB000 + 16'(i));
    bus.in_wr_valid = 1'b1;
    bus.in_wr_addr  = 19'h00104;
    bus.in_wr_data  = 16'hB004;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_full_%0d", i), 64'(bus.out_wr_ready), 64'd0);
      @(negedge clk);
    end
    check_eq("t3_none_issued", 64'(log_q.size()), 64'(base));
    hold = 1'b0;
    t = 0;
    while (!bus.out_wr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("t3_ready_after_pop", 64'(bus.out_wr_ready), 64'd1);
    @(negedge clk);
    bus.in_wr_valid = 1'b0;
    wait_log(base + 5, "t3_issued");
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("t3_order_%0d", i), 64'(log_q[base+i]),
               64'({1'b0, 19'h00100 + 19'(i), 16'hB000 + 16'(i)}));
    repeat (20) @(negedge clk);

    // 4: starvation limit
    hold = 1'b1;
    push(19'h00200, 16'hC200);
    push(19'h00201, 16'hC201);
    bus.in_rd_req  = 1'b1;
    bus.in_rd_addr = 19'h00300;
    @(negedge clk);
    base = log_q.size();
    hold = 1'b0;
    wait_log(base + 20, "t4_issued");
    bus.in_rd_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      e = log_q[base+i];
      check_eq($sformatf("t4_rw_%0d", i), 64'(e[35]), 64'((i == 8 || i == 17) ? 0 : 1));
    end
    e = log_q[base+8];
    check_eq("t4_wr0_addr", 64'(e[34:16]), 64'h00200);
    e = log_q[base+17];
    check_eq("t4_wr1_addr", 64'(e[34:16]), 64'h00201);
    e = log_q[base+18];
    check_eq("t4_rd_addr", 64'(e[34:16]), 64'h00300);
    repeat (30) @(negedge clk);

    // 5: reset during read WAIT
    m_lat = 6;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(19'h00400 + 19'(i), 16'hD000 + 16'(i));
    check_eq("t5_full", 64'(bus.out_wr_ready), 64'd0);
    read(19'h00500);
    base = log_q.size();
    hold = 1'b0;
    wait_log(base + 1, "t5_issued");
    check_eq("t5_read_first", 64'(log_q[base][35]), 64'd1);
    repeat (2) @(negedge clk);
    check_eq("t5_in_wait", 64'(bus.out_sram_start_n), 64'd1);
    v0 = rdv_cnt;
    rst = 1'b1;
    #1;
    check_eq("t5_start_n", 64'(bus.out_sram_start_n), 64'd1);
    check_eq("t5_rd_valid", 64'(bus.out_rd_valid), 64'd0);
    check_eq("t5_rd_ready", 64'(bus.out_rd_ready), 64'd1);
    check_eq("t5_wr_ready", 64'(bus.out_wr_ready), 64'd1);
    check_eq("t5_count", 64'(dut.count_q), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_lat = 2;
    repeat (20) @(negedge clk);
    check_eq("t5_no_return", 64'(rdv_cnt), 64'(v0));
    check_eq("t5_fifo_lost", 64'(log_q.size()), 64'(base + 1));
    push(19'h00600, 16'h0C0C);
    wait_log(base + 2, "t5_resume_wr");
    check_eq("t5_resume_wr_req", 64'(log_q[base+1]), 64'({1'b0, 19'h00600, 16'h0C0C}));
    repeat (10) @(negedge clk);
    read(19'h00601);
    t = 0;
    while (!bus.out_rd_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("t5_resume_rd_data", 64'(bus.out_rd_data), 64'(rdfn(19'h00601)));
    repeat (10) @(negedge clk);

    // 6: simultaneous push/pop at 3 entries, pointer wrap over 10 entries
    hold = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 3; i++) push(19'h00700 + 19'(i), 16'hE000 + 16'(i));
    hold = 1'b0;
    push(19'h00703, 16'hE003);
    check_eq("t6_count_same", 64'(dut.count_q), 64'd3);
    check_eq("t6_ready", 64'(bus.out_wr_ready), 64'd1);
    for (int i = 4; i < 10; i++) push(19'h00700 + 19'(i), 16'hE000 + 16'(i));
    wait_log(base + 10, "t6_issued");
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("t6_order_%0d", i), 64'(log_q[base+i]),
               64'({1'b0, 19'h00700 + 19'(i), 16'hE000 + 16'(i)}));
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/amiv_fb_arbiter.md
Name: amiv_fb_arbiter

Overview:
- Sits directly upstream of the framebuffer SRAM controller and is its only client.
- Merges two traffic streams into single-outstanding SRAM requests: buffered pixel writes from the video capture path, and single-word scanout reads from the display path.
- Reads have priority so the display does not underrun. Writes are held in a small FIFO, and a starvation limit prevents reads from locking writes out.

Parameters:
- FIFO_AW, 2: log2 of write FIFO depth (default depth 4).
- STARVE_MAX, 8: consecutive read grants allowed while the write FIFO is non-empty; after this many, one write is forced.

Ports:
- in_clk  input  1  clock; all logic on rising edge.
- in_reset  input  1  asynchronous, active-high reset.
- in_wr_valid  input  1  capture write request.
- in_wr_addr  input  19  capture word address.
- in_wr_data  input  16  capture pixel data.
- out_wr_ready  output  1  FIFO can accept; a write is accepted when valid&ready.
- in_rd_req  input  1  scanout read request, sampled when out_rd_ready=1.
- in_rd_addr  input  19  scanout word address.
- out_rd_ready  output  1  no read pending.
- out_rd_valid  output  1  one-cycle pulse; out_rd_data valid.
- out_rd_data  output  16  read result, held until next read completes.
- out_sram_start_n  output  1  active-low request strobe to the SRAM controller.
- out_sram_rw  output  1  1=read, 0=write.
- out_sram_fast_write  output  1  constant 0.
- out_sram_addr  output  19  request address.
- out_sram_data  output  16  write data.
- in_sram_busy_n  input  1  controller idle when 1.
- in_sram_data  input  16  controller read data.

Behaviour:
Reset (async, immediate):
- FIFO emptied; read pending cleared; starvation counter = 0; FSM = IDLE.
- Outputs: out_sram_start_n=1, out_sram_rw=1, out_sram_addr=0, out_sram_data=0, out_rd_valid=0, out_rd_data=0, out_wr_ready=1, out_rd_ready=1.
- Reset mid-transaction abandons the request. No result is returned and the FIFO entry is lost.

Write FIFO:
- Depth 2^FIFO_AW; each entry holds 35 bits (addr+data).
- out_wr_ready = !full, registered-free (combinational from count).
- Push on in_wr_valid & out_wr_ready. Pop when a write is granted.
- Push and pop in the same cycle: count unchanged. Push into a full FIFO is impossible because ready=0.
- Pointers wrap modulo depth. Count is FIFO_AW+1 bits.

Read capture:
- When in_rd_req & out_rd_ready: latch in_rd_addr and set rd_pend. out_rd_ready = !rd_pend.

Arbitration (evaluated in IDLE when in_sram_busy_n=1):
- rd_pend and not forced-write → grant read.
- Else FIFO non-empty → grant write.
- Forced-write: starve counter == STARVE_MAX and FIFO non-empty.
- Starve counter: increments on each read grant while FIFO non-empty, saturates at STARVE_MAX, and clears on any write grant or when the FIFO is empty.

FSM:
- IDLE: on grant, drive out_sram_rw/addr/data from the granted source, out_sram_start_n=0, go to ISSUE. With no grant, start_n=1.
- ISSUE: hold start_n=0 and the request fields until in_sram_busy_n=0 is seen, then start_n=1 and go to WAIT.
- WAIT: hold addr/rw/data stable. When in_sram_busy_n=1:
  - read: out_rd_data <= in_sram_data, out_rd_valid=1 for one cycle, clear rd_pend.
  - write: no return.
  - Then go to IDLE.
- A new grant may not be issued in the same cycle as completion. Minimum one IDLE cycle between requests.
- out_sram_addr/data/rw are registered and change only on grant.

Simultaneous events:
- A capture push while the FIFO is being popped, and an in_rd_req arriving during a write transaction, are both accepted. That read is granted on the next IDLE unless forced-write applies.

Test Plan:
1. Reset, single write addr=0x00010 data=0xA5A5, controller model idle → start_n low 1+ cycle with rw=0, addr=0x00010, data=0xA5A5; FIFO empty afterward; out_wr_ready=1 throughout.
2. Read addr=0x7FFFF, model returns 0x1234 → out_rd_valid one pulse with out_rd_data=0x1234; out_rd_ready low from accept to the completion cycle.
3. Push 5 writes back-to-back while the controller is held busy (busy_n=0) → 4 accepted, out_wr_ready=0 on the 5th until first pop; SRAM writes issued in push order with correct addr/data.
4. Continuous reads with 2 writes queued, STARVE_MAX=8 → exactly 8 read grants, then 1 write, then reads resume; counter cleared after the write.
5. Assert in_reset during WAIT of a read → start_n=1, out_rd_valid never pulses, out_rd_ready=1, FIFO count=0 immediately; normal operation resumes after release.
6. Simultaneous push and pop with FIFO at 3 entries → count stays 3; wrap of pointers across 10 entries preserves order.
